// File: rtl/delay_cal_pkg.sv
// rtl/delay_cal_pkg.sv - delay_calibrator configuration, FSM states and max helper
// DELAY_CAL_AVG_EN selects 2^LOG2_SHOTS-shot averaging; otherwise one good shot completes a run.
package delay_cal_pkg;
  localparam int NCHAN   = 4;
  localparam int NBITS   = 4;
  localparam int HOLDOFF = 8;
  localparam int MAXDISC = 4;
`ifdef DELAY_CAL_AVG_EN
  localparam int LOG2_SHOTS = 2;
  localparam int SHIFT      = LOG2_SHOTS;
`else
  localparam int SHIFT      = 0;
`endif
  localparam int SHOTS = 1 << SHIFT;
  localparam int SUMW  = NBITS + SHIFT;
  localparam int WIN   = (1 << NBITS) - 1;
  localparam int DW    = $clog2(MAXDISC + 1);
  localparam int HW    = $clog2(HOLDOFF + 1);
  localparam int GW    = SHIFT + 1;

  typedef logic [NBITS-1:0] delay_t;

  typedef enum logic [2:0] {IDLE, ARMED, OPEN, HOLD, COMPUTE, FAIL} state_t;

  function automatic delay_t max_of(input delay_t v [NCHAN]);
    delay_t m;
    m = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (v[i] > m) m = v[i];
    end
    return m;
  endfunction
endpackage

// File: rtl/delay_calibrator_if.sv
// rtl/delay_calibrator_if.sv - control/channel/result bundle between control logic and delay_calibrator
interface delay_calibrator_if;
  import delay_cal_pkg::*;

  logic             Start;
  logic [NCHAN-1:0] Channels;
  delay_t           Delays [NCHAN];
  logic             Busy;
  logic             Done;
  logic             Valid;
  logic [DW-1:0]    Discards;

  modport master (output Start, Channels, input Delays, Busy, Done, Valid, Discards);
  modport slave  (input Start, Channels, output Delays, Busy, Done, Valid, Discards);
endinterface

// File: rtl/arrival_stamper.sv
// rtl/arrival_stamper.sv - per-channel rise detect, arrival capture and shot-sum accumulator
module arrival_stamper
  import delay_cal_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            chan,
  input  logic            clear,
  input  logic            open,
  input  delay_t          cnt,
  input  logic            commit,
  output logic            hit,
  output logic            cap_now,
  output logic [SUMW-1:0] sum
);
  logic   prev;
  logic   captured;
  delay_t arrival;
  delay_t arr_now;

  // cap_now/arr_now include this cycle's capture so the closing cycle can commit directly
  assign hit     = open & chan & ~prev & ~captured;
  assign cap_now = captured | hit;
  assign arr_now = hit ? cnt : arrival;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev     <= 1'b0;
      captured <= 1'b0;
      arrival  <= '0;
      sum      <= '0;
    end else begin
      prev     <= chan;
      captured <= open & cap_now;
      if (hit) arrival <= cnt;
      if (clear) sum <= '0;
      else if (commit) sum <= sum + SUMW'(arr_now);
    end
  end
endmodule

// File: rtl/delay_calibrator.sv
// rtl/delay_calibrator.sv - skew measurement FSM and delay output stage
// DELAY_CAL_AVG_EN (in delay_cal_pkg) enables multi-shot averaging.
module delay_calibrator
  import delay_cal_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  delay_calibrator_if.slave bus
);
  state_t           state, state_n;
  delay_t           cnt;
  logic [HW-1:0]    hold_cnt;
  logic [DW-1:0]    discards;
  logic [GW-1:0]    good;
  logic             valid;
  delay_t           delays [NCHAN];
  logic [NCHAN-1:0] hit, cap_now;
  logic [SUMW-1:0]  sum [NCHAN];
  delay_t           avg [NCHAN];
  delay_t           peak;
  logic             open, accept, commit, discard;

  assign open = (state == ARMED) || (state == OPEN);

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    arrival_stamper u_stamp (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .chan    (bus.Channels[i]),
      .clear   (accept),
      .open    (open),
      .cnt     (cnt),
      .commit  (commit),
      .hit     (hit[i]),
      .cap_now (cap_now[i]),
      .sum     (sum[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NCHAN; i++) avg[i] = delay_t'(sum[i] >> SHIFT);
    peak = max_of(avg);
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
    case (state)
      IDLE: if (bus.Start) begin
        accept  = 1'b1;
        state_n = ARMED;
      end
      // a shot whose channels all rise in the opening cycle closes without visiting OPEN
      ARMED: if (|hit) begin
        if (&cap_now) begin
          commit  = 1'b1;
          state_n = HOLD;
        end else begin
          state_n = OPEN;
        end
      end
      OPEN: begin
        if (&cap_now) begin
          commit  = 1'b1;
          state_n = HOLD;
        end else if (cnt == NBITS'(WIN - 1)) begin
          discard = 1'b1;
          state_n = (discards == DW'(MAXDISC - 1)) ? FAIL : HOLD;
        end
      end
      HOLD: if (hold_cnt == HW'(HOLDOFF - 1)) begin
        state_n = (good == GW'(SHOTS)) ? COMPUTE : ARMED;
      end
      COMPUTE: state_n = IDLE;
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      discards <= '0;
      good     <= '0;
      valid    <= 1'b0;
      for (int i = 0; i < NCHAN; i++) delays[i] <= '0;
    end else begin
      state    <= state_n;
      cnt      <= (state_n == OPEN) ? cnt + 1'b1 : '0;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      if (accept) begin
        discards <= '0;
        good     <= '0;
        valid    <= 1'b0;
      end else begin
        if (discard) discards <= discards + 1'b1;
        if (commit) good <= good + 1'b1;
        // result is loaded as COMPUTE is entered so it is visible alongside Done
        if (state_n == COMPUTE) begin
          valid <= 1'b1;
          for (int i = 0; i < NCHAN; i++) delays[i] <= peak - avg[i];
        end
      end
    end
  end

  assign bus.Busy     = (state == ARMED) || (state == OPEN) || (state == HOLD);
  assign bus.Done     = (state == COMPUTE) || (state == FAIL);
  assign bus.Valid    = valid;
  assign bus.Discards = discards;
  assign bus.Delays   = delays;
endmodule

// File: tb/tb_delay_calibrator.sv
// tb/tb_delay_calibrator.sv - scoreboard bench for delay_calibrator with a shot-level reference model
module tb_delay_calibrator;
  localparam int NCH  = 4;
  localparam int NB   = 4;
  localparam int HOLD = 8;
  localparam int MAXD = 4;
  localparam int WIN  = 15;
`ifdef DELAY_CAL_AVG_EN
  localparam int SHOTS = 4;
`else
  localparam int SHOTS = 1;
`endif

  typedef struct packed {
    logic                   valid;
    logic [NCH-1:0][NB-1:0] delays;
    logic [7:0]             discards;
    logic [31:0]            done_cyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  int shot[NCH];
  int sums[NCH];
  int prev_del[NCH];
  int goods, discs;
  bit run_done;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  delay_calibrator_if bus ();
  delay_calibrator dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus.Done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, int'(e.done_cyc));
          check("valid", bus.Valid, e.valid);
          check("discards", bus.Discards, e.discards);
          check("busy_at_done", bus.Busy, 0);
          for (int i = 0; i < NCH; i++)
            check($sformatf("delay%0d", i), bus.Delays[i], e.delays[i]);
        end
      end
    end
  end

  task automatic start_run();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    check("busy_after_start", bus.Busy, 1);
    check("valid_after_start", bus.Valid, 0);
    for (int i = 0; i < NCH; i++) sums[i] = 0;
    goods = 0;
    discs = 0;
    run_done = 0;
  endtask

  // offsets < 0 mean the channel never rises in that shot
  task automatic do_shot(input int o0, input int o1, input int o2, input int o3, input bit extra);
    int   mn, mx, f, m;
    bit   good;
    int   avg[NCH];
    exp_t e;
    shot[0] = o0; shot[1] = o1; shot[2] = o2; shot[3] = o3;
    mn = 99; mx = 0; good = 1;
    for (int i = 0; i < NCH; i++) begin
      if (shot[i] < 0) good = 0;
      else if (shot[i] < mn) mn = shot[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (shot[i] >= 0) begin
        shot[i] -= mn;
        if (shot[i] > mx) mx = shot[i];
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge Clk);
    f = cyc;
    if (good) begin
      goods++;
      for (int i = 0; i < NCH; i++) sums[i] += shot[i];
      if (goods == SHOTS) begin
        m = 0;
        for (int i = 0; i < NCH; i++) begin
          avg[i] = sums[i] / SHOTS;
          if (avg[i] > m) m = avg[i];
        end
        e.valid = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          prev_del[i] = m - avg[i];
          e.delays[i] = NB'(prev_del[i]);
        end
        e.discards = 8'(discs);
        e.done_cyc = 32'(f + mx + HOLD + 1);
        q.push_back(e);
        run_done = 1;
      end
    end else begin
      discs++;
      if (discs == MAXD) begin
        e.valid = 1'b0;
        for (int i = 0; i < NCH; i++) e.delays[i] = NB'(prev_del[i]);
        e.discards = 8'(discs);
        e.done_cyc = 32'(f + WIN);
        q.push_back(e);
        run_done = 1;
      end
    end
    for (int k = 0; k < WIN; k++) begin
      for (int i = 0; i < NCH; i++)
        bus.Channels[i] = (shot[i] == k) || (extra && i == 0 && k == 3);
      bus.Start = extra && (k == 2);
      @(negedge Clk);
    end
    bus.Start = 1'b0;
    bus.Channels = '0;
    repeat (HOLD + 1) @(negedge Clk);
  endtask

  task automatic finish_run();
    repeat (2) @(negedge Clk);
    check("result_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int r[NCH];
    int miss, j;
    bus.Start = 1'b0;
    bus.Channels = '0;
    for (int i = 0; i < NCH; i++) prev_del[i] = 0;
    repeat (3) @(negedge Clk);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_valid", bus.Valid, 0);
    check("rst_discards", bus.Discards, 0);
    for (int i = 0; i < NCH; i++) check($sformatf("rst_delay%0d", i), bus.Delays[i], 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    start_run(); while (!run_done) do_shot(0, 0, 0, 0, 0); finish_run();
    start_run(); while (!run_done) do_shot(0, 2, 5, 1, 0); finish_run();
    start_run(); while (!run_done) do_shot(0, 1, 2, -1, 0); finish_run();
    start_run(); j = 0;
    while (!run_done) begin
      do_shot(0, (j % 2 == 1) ? 3 : 2, 0, 0, 0);
      j++;
    end
    finish_run();
    start_run(); while (!run_done) do_shot(0, 2, 5, 1, 1); finish_run();
    start_run(); while (!run_done) do_shot(0, 7, 14, 3, 0); finish_run();

    start_run();
    bus.Channels = 4'b0001;
    @(negedge Clk);
    bus.Channels = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.Busy, 0);
    check("midrst_valid", bus.Valid, 0);
    check("midrst_discards", bus.Discards, 0);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("midrst_delay%0d", i), bus.Delays[i], 0);
      prev_del[i] = 0;
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    start_run(); while (!run_done) do_shot(0, 2, 5, 1, 0); finish_run();

    repeat (12) begin
      start_run();
      while (!run_done) begin
        miss = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NCH - 1)) : -1;
        for (int i = 0; i < NCH; i++) r[i] = (i == miss) ? -1 : int'($urandom_range(0, WIN - 1));
        do_shot(r[0], r[1], r[2], r[3], 0);
      end
      finish_run();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
